// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: walks the instruction RAM from a start address,
// issuing each word to the decoder as a single-cycle instr_enable pulse.
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [15:0]            instr_count,
    input  logic                   stall,
    input  logic                   resume,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rd_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_enable,
    output logic                   busy,
    output logic                   held,
    output logic                   done,
    output logic [15:0]            issued_count
);

    localparam logic [7:0] OP_END  = 8'h82;
    localparam logic [7:0] OP_HOLD = 8'h44;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [15:0]            remaining;
    logic [INSTR_WIDTH-1:0] ibuf;
    logic                   start_ok;
    logic                   issue_go;
    logic [7:0]             ibuf_op;

    function automatic logic [7:0] opcode_of(input logic [INSTR_WIDTH-1:0] word);
        return word[INSTR_WIDTH-1 -: 8];
    endfunction

    // Address arithmetic is modulo 2^ADDR_WIDTH, so the carry simply drops off.
    function automatic logic [ADDR_WIDTH-1:0] pc_next(input logic [ADDR_WIDTH-1:0] cur);
        return cur + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign issue_go = (state == S_ISSUE) && !stall;
    assign ibuf_op  = opcode_of(ibuf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (instr_count == 16'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                // End opcode wins over hold, which wins over count exhaustion.
                if (!stall) begin
                    if (ibuf_op == OP_END) begin
                        state_nxt = S_DONE;
                    end else if (ibuf_op == OP_HOLD) begin
                        state_nxt = S_HOLD;
                    end else if (remaining <= 16'd1) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (resume) begin
                    state_nxt = (remaining == 16'd0) ? S_DONE : S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            remaining    <= '0;
            ibuf         <= '0;
            instruction  <= '0;
            instr_enable <= 1'b0;
            issued_count <= '0;
        end else begin
            instr_enable <= issue_go;
            if (start_ok) begin
                pc           <= start_addr;
                remaining    <= instr_count;
                issued_count <= '0;
            end
            // RAM data is valid exactly one cycle after the FETCH strobe.
            if (state == S_WAIT) begin
                ibuf <= mem_rd_data;
            end
            if (issue_go) begin
                instruction  <= ibuf;
                issued_count <= issued_count + 16'd1;
                remaining    <= remaining - 16'd1;
                pc           <= pc_next(pc);
            end
        end
    end

    always_comb begin
        mem_rd_en   = (state == S_FETCH);
        mem_rd_addr = (state == S_FETCH) ? pc : '0;
        busy        = (state != S_IDLE) && (state != S_DONE);
        held        = (state == S_HOLD);
        done        = (state == S_DONE);
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected fetches and issue pulses are
// queued with their cycle numbers and matched by an independent monitor.
module tb_instruction_fetch;

    localparam int AW = 4;
    localparam int IW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [15:0]   instr_count;
    logic          stall;
    logic          resume;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [IW-1:0] mem_rd_data;
    logic [IW-1:0] instruction;
    logic          instr_enable;
    logic          busy;
    logic          held;
    logic          done;
    logic [15:0]   issued_count;

    instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .instr_count  (instr_count),
        .stall        (stall),
        .resume       (resume),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .instruction  (instruction),
        .instr_enable (instr_enable),
        .busy         (busy),
        .held         (held),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    typedef struct {
        logic [IW-1:0] data;
        logic [15:0]   cnt;
        int            cyc;
    } pulse_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } fetch_t;

    pulse_t pq[$];
    fetch_t fq[$];
    int     n_pass = 0;
    int     n_tot  = 0;
    int     t0     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [IW-1:0] mk(input logic [7:0] op, input logic [7:0] tag);
        return {op, 48'h5A5A_0000_C3C3, tag};
    endfunction

    task automatic exp_fetch(input logic [AW-1:0] a, input int k);
        fetch_t f;
        f.addr = a;
        f.cyc  = t0 + k;
        fq.push_back(f);
    endtask

    task automatic exp_pulse(input logic [IW-1:0] d, input logic [15:0] c, input int k);
        pulse_t p;
        p.data = d;
        p.cnt  = c;
        p.cyc  = t0 + k;
        pq.push_back(p);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives a one-cycle start; edge 0 is the posedge right after this negedge.
    task automatic launch(input logic [AW-1:0] a, input logic [15:0] n);
        start_addr  = a;
        instr_count = n;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    always @(negedge clk) begin
        fetch_t f;
        pulse_t p;
        if (!rst && mem_rd_en) begin
            if (fq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_fetch: got addr %0d at cycle %0d, expected no fetch", mem_rd_addr, cyc);
            end else begin
                f = fq.pop_front();
                chk("fetch_addr", 64'(mem_rd_addr), 64'(f.addr));
                chk("fetch_cycle", 64'(cyc), 64'(f.cyc));
            end
        end
        if (!rst && instr_enable) begin
            if (pq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_pulse: got instruction 0x%0h at cycle %0d, expected no pulse", instruction, cyc);
            end else begin
                p = pq.pop_front();
                chk("pulse_instruction", instruction, p.data);
                chk("pulse_issued_count", 64'(issued_count), 64'(p.cnt));
                chk("pulse_cycle", 64'(cyc), 64'(p.cyc));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_instruction"}, instruction, 64'h0);
        chk({tag, "_instr_enable"}, 64'(instr_enable), 64'h0);
        chk({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'h0);
        chk({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_held"}, 64'(held), 64'h0);
        chk({tag, "_done"}, 64'(done), 64'h0);
        chk({tag, "_issued_count"}, 64'(issued_count), 64'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; resume = 1'b0;
        start_addr = '0; instr_count = '0;
        for (int i = 0; i < 16; i++) ram[i] = mk(8'h01, 8'(i));
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic run: three plain instructions from address 5.
        ram[5] = mk(8'h01, 8'hA5); ram[6] = mk(8'h01, 8'hA6); ram[7] = mk(8'h01, 8'hA7);
        t0 = cyc;
        exp_fetch(4'd5, 1); exp_fetch(4'd6, 4); exp_fetch(4'd7, 7);
        exp_pulse(ram[5], 16'd1, 4); exp_pulse(ram[6], 16'd2, 7); exp_pulse(ram[7], 16'd3, 10);
        launch(4'd5, 16'd3);
        at_cycle(t0 + 9);  chk("basic_done_early", 64'(done), 64'h0);
        at_cycle(t0 + 10); chk("basic_done", 64'(done), 64'h1);
        chk("basic_busy", 64'(busy), 64'h0);
        chk("basic_issued", 64'(issued_count), 64'd3);
        at_cycle(t0 + 12);

        // End opcode at address 1 cuts a 10-instruction program short.
        ram[0] = mk(8'h01, 8'h20); ram[1] = mk(8'h82, 8'h21); ram[2] = mk(8'h01, 8'h22);
        t0 = cyc;
        exp_fetch(4'd0, 1); exp_fetch(4'd1, 4);
        exp_pulse(ram[0], 16'd1, 4); exp_pulse(ram[1], 16'd2, 7);
        launch(4'd0, 16'd10);
        at_cycle(t0 + 6); chk("end_done_early", 64'(done), 64'h0);
        at_cycle(t0 + 7); chk("end_done", 64'(done), 64'h1);
        chk("end_issued", 64'(issued_count), 64'd2);
        at_cycle(t0 + 14);

        // Hold opcode parks the sequencer until resume.
        ram[0] = mk(8'h44, 8'h30); ram[1] = mk(8'h81, 8'h31);
        t0 = cyc;
        exp_fetch(4'd0, 1); exp_fetch(4'd1, 9);
        exp_pulse(ram[0], 16'd1, 4); exp_pulse(ram[1], 16'd2, 12);
        launch(4'd0, 16'd2);
        at_cycle(t0 + 3); chk("hold_held_before", 64'(held), 64'h0);
        at_cycle(t0 + 4); chk("hold_held_rise", 64'(held), 64'h1);
        chk("hold_busy", 64'(busy), 64'h1);
        at_cycle(t0 + 8); chk("hold_held_last", 64'(held), 64'h1);
        resume = 1'b1;
        at_cycle(t0 + 9); resume = 1'b0;
        chk("hold_held_release", 64'(held), 64'h0);
        at_cycle(t0 + 12); chk("hold_done", 64'(done), 64'h1);
        at_cycle(t0 + 14);

        // Stall for four ISSUE cycles, then the PC wraps from 15 to 0.
        ram[15] = mk(8'h01, 8'h4F); ram[0] = mk(8'h01, 8'h40);
        t0 = cyc;
        exp_fetch(4'd15, 1); exp_fetch(4'd0, 8);
        exp_pulse(ram[15], 16'd1, 8); exp_pulse(ram[0], 16'd2, 11);
        launch(4'd15, 16'd2);
        at_cycle(t0 + 2); stall = 1'b1;
        at_cycle(t0 + 5); chk("stall_busy", 64'(busy), 64'h1);
        at_cycle(t0 + 7); stall = 1'b0;
        at_cycle(t0 + 11); chk("stall_done", 64'(done), 64'h1);
        at_cycle(t0 + 13);

        // Zero count goes straight to DONE without touching the RAM.
        t0 = cyc;
        launch(4'd3, 16'd0);
        chk("zero_done", 64'(done), 64'h1);
        chk("zero_issued", 64'(issued_count), 64'h0);
        chk("zero_busy", 64'(busy), 64'h0);
        at_cycle(t0 + 4);

        // A second start while busy must not disturb the running program.
        ram[10] = mk(8'h01, 8'h5A); ram[11] = mk(8'h01, 8'h5B);
        t0 = cyc;
        exp_fetch(4'd10, 1); exp_fetch(4'd11, 4);
        exp_pulse(ram[10], 16'd1, 4); exp_pulse(ram[11], 16'd2, 7);
        launch(4'd10, 16'd2);
        at_cycle(t0 + 2);
        start_addr = 4'd3; instr_count = 16'd5; start = 1'b1;
        at_cycle(t0 + 3); start = 1'b0;
        at_cycle(t0 + 7); chk("busy_start_done", 64'(done), 64'h1);
        chk("busy_start_issued", 64'(issued_count), 64'd2);
        at_cycle(t0 + 10);

        // Reset in WAIT clears everything; a fresh start then runs normally.
        ram[8] = mk(8'h01, 8'h68); ram[9] = mk(8'h01, 8'h69);
        t0 = cyc;
        exp_fetch(4'd8, 1);
        launch(4'd8, 16'd2);
        at_cycle(t0 + 2); rst = 1'b1;
        at_cycle(t0 + 3);
        chk_all_zero("midrst");
        rst = 1'b0;
        at_cycle(t0 + 4);
        t0 = cyc;
        exp_fetch(4'd9, 1);
        exp_pulse(ram[9], 16'd1, 4);
        launch(4'd9, 16'd1);
        at_cycle(t0 + 4); chk("post_rst_done", 64'(done), 64'h1);
        chk("post_rst_issued", 64'(issued_count), 64'd1);
        at_cycle(t0 + 6);

        chk("fetch_queue_drained", 64'(fq.size()), 64'h0);
        chk("pulse_queue_drained", 64'(pq.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
